qam_frame_mapper: RTL and testbench
===================================

# qam_frame_mapper

Parametrised successor to the fixed 64-QAM baseband front end. It takes a serial bit stream and hunts for a frame sync word. It then Gray-maps a fixed-length payload into I/Q level indices for square QAM of runtime-selectable order: QPSK, 16, 64 or 256-QAM. Adds sync detection, per-frame mode latching, a one-deep pending buffer against I/Q FIFO backpressure, and overflow reporting. Sits between the serial data source and the I/Q data FIFO feeding the modulator datapath.

## Interface
- MAX_M, 4, max bits per axis (4 → up to 256-QAM); sets I/Q width
- SYNC_LEN, 16, sync word length in bits
- SYNC_WORD, 16'hA5C3, sync pattern, MSB received first
- PAYLOAD_SYMS, 64, symbols mapped per frame (≥1)
- data_clk  in  1  sole clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- enable  in  1  block enable; low aborts any frame
- data_in  in  1  serial bit, sampled every data_clk while enable=1
- mode  in  2  0=QPSK, 1=16-QAM, 2=64-QAM, 3=256-QAM (m=mode+1 bits/axis); values with m>MAX_M saturate to m=MAX_M
- i_q_data_fifo_full  in  1  downstream FIFO full
- i_data  out  MAX_M  I level index, binary, zero-extended
- q_data  out  MAX_M  Q level index, binary, zero-extended
- new_symbol  out  1  one-cycle write strobe for i_data/q_data
- mapping  out  1  high while in MAP state
- overflow  out  1  sticky: a symbol was dropped

## Operation
- States: IDLE, HUNT, MAP. After reset: IDLE. IDLE→HUNT when enable=1. Any state→IDLE when enable=0. Partial symbol, pending buffer and sync shifter are cleared; overflow is cleared.
- HUNT: shift data_in into SYNC_LEN-bit register, newest at LSB. On the cycle the register (including the current bit) equals SYNC_WORD, latch m from mode and go to MAP. Sync register is cleared on the transition.
- MAP: accumulate 2m bits MSB-first. First m bits = I Gray code, next m = Q Gray code. On the 2m-th bit, Gray→binary each axis (b[k]=g[k]^b[k+1]) and produce a symbol. After PAYLOAD_SYMS symbols produced (including dropped ones), go to HUNT.
- mode changes outside the sync-detect cycle have no effect until the next frame.
- Output/backpressure: symbol completes with full=0 and no pending → registered to outputs, new_symbol=1 next cycle.
  - full=1 → stored in pending buffer.
  - Pending is issued on the first cycle full=0, and completes before any newer symbol.
  - Symbol completing while pending is still occupied → newer symbol dropped, overflow←1.
  - Pending issue and a new completion in the same cycle → pending issued, new one moves to pending.
- Pending is drained even after return to HUNT, unless enable=0 or rst.

## Timing
- Reset values: i_data=0, q_data=0, new_symbol=0, mapping=0, overflow=0, state IDLE, counters 0.
- First payload bit is the data_in sampled the cycle after the sync-completing bit. mapping=1 from that cycle through the cycle sampling the last bit of symbol PAYLOAD_SYMS.
- Latency: last bit of symbol sampled at edge N → new_symbol high for cycle N+1 (unstalled). i_data/q_data are valid with the strobe and hold until the next strobe.
- new_symbol never asserted while i_q_data_fifo_full=1.
- Symbol throughput: one per 2m cycles; QPSK gives a strobe every 2 cycles.
- rst or enable=0 mid-frame: effective next edge, no strobe from the partial symbol.

## Structure
- Package qam_frame_pkg holds the state enum (IDLE/HUNT/MAP), mode encodings, and a gray2bin function parametrised on MAX_M.
- One sub-module, qam_sync_detector: shift register plus compare, outputs a one-cycle sync_hit. The FSM, bit accumulator, symbol counter and pending buffer stay in the top.

## Test plan
- Basic 64-QAM: mode=2, send A5C3 then bits 110 010 (I Gray 110, Q Gray 010) → one cycle later new_symbol=1, i_data=4'd4, q_data=4'd3, mapping=1.
- Mode sweep: frames with mode 0,1,3 (PAYLOAD_SYMS=4) → strobes every 2/4/8 cycles. Binary outputs match the Gray reference model. mapping drops after the 4th symbol. mode toggled mid-frame has no effect.
- False/overlapping sync: stream containing A5C2 then A5C3 preceded by 1 partial match → only A5C3 triggers MAP; no strobes before it.
- Backpressure: full=1 for 10 cycles during QPSK frame → one symbol pending, following ones dropped, overflow=1. On full=0, pending issued first and no strobe during full.
- Abort: enable=0 on bit 3 of symbol 5 → next cycle state IDLE, mapping=0, no strobe. Re-enable and resend sync → frame restarts at symbol 0.
- Reset mid-frame with pending symbol: rst=1 one cycle → all outputs 0 next cycle, pending discarded, overflow cleared.

Source files
------------

// File: rtl/qam_frame_pkg.sv
// Shared types and helpers for the QAM frame mapper: FSM states, mode
// encodings and Gray-to-binary conversion.
package qam_frame_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HUNT,
        MAP
    } state_t;

    typedef enum logic [1:0] {
        MODE_QPSK   = 2'd0,
        MODE_QAM16  = 2'd1,
        MODE_QAM64  = 2'd2,
        MODE_QAM256 = 2'd3
    } qam_mode_t;

    // Widest axis the helper converts; MAX_M-wide codes are zero-extended into it.
    localparam int unsigned GRAY_W = 8;

    function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] g);
        logic [GRAY_W-1:0] b;
        b[GRAY_W-1] = g[GRAY_W-1];
        for (int unsigned i = 1; i < GRAY_W; i++) begin
            b[GRAY_W-1-i] = g[GRAY_W-1-i] ^ b[GRAY_W-i];
        end
        return b;
    endfunction

endpackage

// File: rtl/qam_sync_detector.sv
// Serial sync-word hunter: shifts bits in at the LSB and flags the cycle on
// which the register, including the current bit, equals the sync word.
module qam_sync_detector
    import qam_frame_pkg::*;
#(
    parameter int unsigned         SYNC_LEN  = 16,
    parameter logic [SYNC_LEN-1:0] SYNC_WORD = 16'hA5C3
) (
    input  logic data_clk,
    input  logic rst,
    input  logic clear,
    input  logic shift_en,
    input  logic data_in,
    output logic sync_hit
);

    logic [SYNC_LEN-1:0] sreg_q;
    logic [SYNC_LEN-1:0] shifted;

    assign shifted  = SYNC_LEN'({sreg_q, data_in});
    assign sync_hit = shift_en && (shifted == SYNC_WORD);

    always_ff @(posedge data_clk) begin
        if (rst || clear || sync_hit) begin
            sreg_q <= '0;
        end else if (shift_en) begin
            sreg_q <= shifted;
        end
    end

endmodule

// File: rtl/qam_frame_mapper.sv
// Frame-synchronised Gray QAM mapper: hunts for the sync word, then maps a
// fixed-length payload into I/Q level indices with a one-deep pending buffer.
module qam_frame_mapper
    import qam_frame_pkg::*;
#(
    parameter int unsigned         MAX_M        = 4,
    parameter int unsigned         SYNC_LEN     = 16,
    parameter logic [SYNC_LEN-1:0] SYNC_WORD    = 16'hA5C3,
    parameter int unsigned         PAYLOAD_SYMS = 64
) (
    input  logic             data_clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             data_in,
    input  logic [1:0]       mode,
    input  logic             i_q_data_fifo_full,
    output logic [MAX_M-1:0] i_data,
    output logic [MAX_M-1:0] q_data,
    output logic             new_symbol,
    output logic             mapping,
    output logic             overflow
);

    localparam int unsigned M_W   = $clog2(MAX_M + 1);
    localparam int unsigned ACC_W = 2 * MAX_M;
    localparam int unsigned BC_W  = $clog2(ACC_W + 1);
    localparam int unsigned SC_W  = $clog2(PAYLOAD_SYMS + 1);

    state_t state_q, state_d;

    logic [M_W-1:0]   m_q;
    logic [M_W-1:0]   m_new;
    logic [2:0]       mode_m;
    logic [ACC_W-2:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] axis_mask;
    logic [BC_W-1:0]  bit_cnt_q;
    logic [BC_W-1:0]  two_m;
    logic [SC_W-1:0]  sym_cnt_q;

    logic             pend_valid_q;
    logic [MAX_M-1:0] pend_i_q, pend_q_q;

    logic             hunt_en, sync_hit, map_bit, sym_done, last_sym;
    logic [MAX_M-1:0] i_gray, q_gray, i_bin, q_bin;

    qam_sync_detector #(
        .SYNC_LEN  (SYNC_LEN),
        .SYNC_WORD (SYNC_WORD)
    ) u_sync (
        .data_clk (data_clk),
        .rst      (rst),
        .clear    (!enable),
        .shift_en (hunt_en),
        .data_in  (data_in),
        .sync_hit (sync_hit)
    );

    // Bits per axis, saturated to what the output width can carry.
    assign mode_m = 3'(mode) + 3'd1;
    assign m_new  = (32'(mode_m) > MAX_M) ? M_W'(MAX_M) : M_W'(mode_m);

    assign hunt_en  = (state_q == HUNT) && enable;
    assign map_bit  = (state_q == MAP) && enable;
    assign mapping  = (state_q == MAP);

    assign acc_d     = {acc_q, data_in};
    assign two_m     = BC_W'({m_q, 1'b0});
    assign sym_done  = map_bit && (bit_cnt_q == two_m - BC_W'(1));
    assign last_sym  = (sym_cnt_q == SC_W'(PAYLOAD_SYMS - 1));
    assign axis_mask = ~({ACC_W{1'b1}} << m_q);

    assign i_gray = MAX_M'((acc_d >> m_q) & axis_mask);
    assign q_gray = MAX_M'(acc_d & axis_mask);
    assign i_bin  = MAX_M'(gray2bin(GRAY_W'(i_gray)));
    assign q_bin  = MAX_M'(gray2bin(GRAY_W'(q_gray)));

    always_ff @(posedge data_clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = HUNT;
                HUNT:    if (sync_hit) state_d = MAP;
                MAP:     if (sym_done && last_sym) state_d = HUNT;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge data_clk) begin
        if (rst) begin
            m_q          <= '0;
            acc_q        <= '0;
            bit_cnt_q    <= '0;
            sym_cnt_q    <= '0;
            pend_valid_q <= 1'b0;
            pend_i_q     <= '0;
            pend_q_q     <= '0;
            i_data       <= '0;
            q_data       <= '0;
            new_symbol   <= 1'b0;
            overflow     <= 1'b0;
        end else if (!enable) begin
            acc_q        <= '0;
            bit_cnt_q    <= '0;
            sym_cnt_q    <= '0;
            pend_valid_q <= 1'b0;
            new_symbol   <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            new_symbol <= 1'b0;
            if (sync_hit) begin
                m_q <= m_new;
            end

            if (map_bit) begin
                if (sym_done) begin
                    acc_q     <= '0;
                    bit_cnt_q <= '0;
                    sym_cnt_q <= last_sym ? '0 : sym_cnt_q + SC_W'(1);
                end else begin
                    acc_q     <= acc_d[ACC_W-2:0];
                    bit_cnt_q <= bit_cnt_q + BC_W'(1);
                end
            end

            // The pending symbol always leaves before a newer one; a completion
            // in the same cycle simply takes its place in the buffer.
            if (pend_valid_q && !i_q_data_fifo_full) begin
                i_data     <= pend_i_q;
                q_data     <= pend_q_q;
                new_symbol <= 1'b1;
                if (sym_done) begin
                    pend_i_q <= i_bin;
                    pend_q_q <= q_bin;
                end else begin
                    pend_valid_q <= 1'b0;
                end
            end else if (sym_done) begin
                if (pend_valid_q) begin
                    overflow <= 1'b1;
                end else if (!i_q_data_fifo_full) begin
                    i_data     <= i_bin;
                    q_data     <= q_bin;
                    new_symbol <= 1'b1;
                end else begin
                    pend_valid_q <= 1'b1;
                    pend_i_q     <= i_bin;
                    pend_q_q     <= q_bin;
                end
            end
        end
    end

endmodule

// File: tb/tb_qam_frame_mapper.sv
// Scoreboard bench for qam_frame_mapper: the sender knows the frame layout and
// pushes expected symbols; every cycle the strobe is compared against the queue.
module tb_qam_frame_mapper;

    localparam int unsigned MAX_M = 4;
    localparam int unsigned P     = 8;

    logic             data_clk = 1'b0;
    logic             rst, enable, data_in, fifo_full;
    logic [1:0]       mode;
    logic [MAX_M-1:0] i_data, q_data;
    logic             new_symbol, mapping, overflow;

    always #5 data_clk = ~data_clk;

    qam_frame_mapper #(
        .MAX_M        (MAX_M),
        .SYNC_LEN     (16),
        .SYNC_WORD    (16'hA5C3),
        .PAYLOAD_SYMS (P)
    ) dut (
        .data_clk           (data_clk),
        .rst                (rst),
        .enable             (enable),
        .data_in            (data_in),
        .mode               (mode),
        .i_q_data_fifo_full (fifo_full),
        .i_data             (i_data),
        .q_data             (q_data),
        .new_symbol         (new_symbol),
        .mapping            (mapping),
        .overflow           (overflow)
    );

    typedef struct packed {
        logic [MAX_M-1:0] i;
        logic [MAX_M-1:0] q;
    } sym_t;

    sym_t             sb[$];
    int               n_tests = 0;
    int               n_fail  = 0;
    int               bp_left = 0;
    logic             m_pv = 1'b0;
    logic [MAX_M-1:0] m_pi = '0, m_pq = '0;
    logic             exp_ovf = 1'b0;
    logic             exp_map = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [MAX_M-1:0] ref_bin(input logic [MAX_M-1:0] g);
        logic [MAX_M-1:0] r;
        for (int k = 0; k < MAX_M; k++) r[k] = ^(g >> k);
        return r;
    endfunction

    // One clock: drive, update the reference model at the edge, check #1 later.
    task automatic step(input logic b, input logic done,
                        input logic [MAX_M-1:0] ei, input logic [MAX_M-1:0] eq);
        sym_t e;
        logic exp_strobe;
        data_in   = b;
        fifo_full = (bp_left != 0);
        if (bp_left != 0) bp_left--;
        @(posedge data_clk);
        if (rst || !enable) begin
            m_pv = 1'b0; exp_ovf = 1'b0; exp_map = 1'b0;
        end else if (m_pv && !fifo_full) begin
            sb.push_back('{i: m_pi, q: m_pq});
            if (done) begin m_pi = ei; m_pq = eq; end
            else m_pv = 1'b0;
        end else if (done) begin
            if (m_pv) exp_ovf = 1'b1;
            else if (!fifo_full) sb.push_back('{i: ei, q: eq});
            else begin m_pv = 1'b1; m_pi = ei; m_pq = eq; end
        end
        #1;
        exp_strobe = (sb.size() != 0);
        check_eq("strobe", 32'(new_symbol), 32'(exp_strobe));
        if (exp_strobe) begin
            e = sb.pop_front();
            if (new_symbol) begin
                check_eq("i_data", 32'(i_data), 32'(e.i));
                check_eq("q_data", 32'(q_data), 32'(e.q));
            end
        end
        check_eq("strobe_while_full", 32'(new_symbol & fifo_full), 32'd0);
        check_eq("overflow", 32'(overflow), 32'(exp_ovf));
        check_eq("mapping", 32'(mapping), 32'(exp_map));
    endtask

    task automatic send_bits(input logic [15:0] v, input int n);
        for (int k = n - 1; k >= 0; k--) step(v[k], 1'b0, '0, '0);
    endtask

    task automatic send_sync();
        logic [15:0] w = 16'hA5C3;
        for (int k = 15; k >= 0; k--) begin
            if (k == 0) exp_map = 1'b1;
            step(w[k], 1'b0, '0, '0);
        end
    endtask

    task automatic send_symbol(input int m, input logic [MAX_M-1:0] gi,
                               input logic [MAX_M-1:0] gq, input logic last);
        for (int k = m - 1; k >= 0; k--) step(gi[k], 1'b0, '0, '0);
        for (int k = m - 1; k >= 1; k--) step(gq[k], 1'b0, '0, '0);
        if (last) exp_map = 1'b0;
        step(gq[0], 1'b1, ref_bin(gi), ref_bin(gq));
    endtask

    task automatic send_rand_syms(input int m, input int first, input int count);
        logic [MAX_M-1:0] gi, gq;
        for (int s = first; s < first + count; s++) begin
            gi = MAX_M'($urandom_range(0, (1 << m) - 1));
            gq = MAX_M'($urandom_range(0, (1 << m) - 1));
            send_symbol(m, gi, gq, s == P - 1);
        end
    endtask

    task automatic send_frame(input logic [1:0] md, input logic toggle);
        mode = md;
        send_sync();
        if (toggle) mode = ~md;
        send_rand_syms(int'(md) + 1, 0, P);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; enable = 1'b0; mode = 2'd0; data_in = 1'b0; fifo_full = 1'b0;
        step(1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b0, '0, '0);
        check_eq("rst_i", 32'(i_data), 32'd0);
        check_eq("rst_q", 32'(q_data), 32'd0);
        rst = 1'b0; enable = 1'b1;
        step(1'b0, 1'b0, '0, '0);

        // Basic 64-QAM: Gray 110/010 maps to levels 4/3.
        mode = 2'd2;
        send_sync();
        send_symbol(3, 4'b0110, 4'b0010, 1'b0);
        check_eq("basic_i", 32'(i_data), 32'd4);
        check_eq("basic_q", 32'(q_data), 32'd3);
        check_eq("basic_map", 32'(mapping), 32'd1);
        send_rand_syms(3, 1, P - 1);

        // Mode sweep with a mode change right after sync.
        send_frame(2'd0, 1'b1);
        send_frame(2'd1, 1'b1);
        send_frame(2'd3, 1'b1);

        // Partial and near-miss sync words must not open a frame.
        send_bits(16'h00A5, 8);
        send_bits(16'hA5C2, 16);
        send_frame(2'd1, 1'b0);

        // Backpressure on a QPSK frame: one pending, four dropped.
        mode = 2'd0;
        send_sync();
        bp_left = 10;
        send_rand_syms(1, 0, P);
        check_eq("ovf_sticky", 32'(overflow), 32'd1);

        // Abort on bit 3 of symbol 5, then restart from symbol 0.
        mode = 2'd2;
        send_sync();
        send_rand_syms(3, 0, 4);
        send_bits(16'h0002, 2);
        enable = 1'b0;
        step(1'b1, 1'b0, '0, '0);
        enable = 1'b1;
        step(1'b0, 1'b0, '0, '0);
        send_frame(2'd2, 1'b0);

        // Reset mid-frame with a pending symbol and overflow set.
        mode = 2'd0;
        send_sync();
        bp_left = 20;
        send_rand_syms(1, 0, 3);
        step(1'b1, 1'b0, '0, '0);
        rst = 1'b1;
        step(1'b0, 1'b0, '0, '0);
        rst = 1'b0;
        bp_left = 0;
        check_eq("rst2_i", 32'(i_data), 32'd0);
        check_eq("rst2_q", 32'(q_data), 32'd0);
        check_eq("rst2_ovf", 32'(overflow), 32'd0);
        for (int k = 0; k < 6; k++) step(1'b0, 1'b0, '0, '0);
        send_frame(2'd3, 1'b0);

        check_eq("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
